// File: rtl/maze_grid_controller_if.sv
// ============================================================================
// Module   : maze_grid_controller_if
// Summary  : GPIO packet input, grid read port and status bundle for the
//            maze-grid controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface maze_grid_controller_if;
    logic [4:0] packet;
    logic       packet_valid;
    logic [1:0] rd_row;
    logic [2:0] rd_col;
    logic [1:0] rd_data;
    logic [1:0] cur_row;
    logic [2:0] cur_col;
    logic       cur_valid;
    logic       update_pulse;
    logic       error_pulse;
    logic [4:0] visited_count;
    logic       done;

    modport master (
        output packet, packet_valid, rd_row, rd_col,
        input  rd_data, cur_row, cur_col, cur_valid, update_pulse,
               error_pulse, visited_count, done
    );

    modport slave (
        input  packet, packet_valid, rd_row, rd_col,
        output rd_data, cur_row, cur_col, cur_valid, update_pulse,
               error_pulse, visited_count, done
    );
endinterface

`default_nettype wire

// File: rtl/maze_grid_controller.sv
// ============================================================================
// Module   : maze_grid_controller
// Summary  : Debounces robot position packets and sequences updates to the
//            4x5 maze-grid state memory that the pixel path reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maze_grid_controller #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    maze_grid_controller_if.slave  bus
);

    localparam logic [1:0] c_cell_unvisited = 2'b00;
    localparam logic [1:0] c_cell_visited   = 2'b01;
    localparam logic [1:0] c_cell_current   = 2'b10;
    localparam logic [4:0] c_all_cells      = 5'd20;
    localparam logic [2:0] c_max_col        = 3'd4;
    localparam logic [7:0] c_stable_last    = 8'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILTER   = 3'd1,
        S_CHECK    = 3'd2,
        S_CLEAR    = 3'd3,
        S_WRITE    = 3'd4,
        S_WAIT_LOW = 3'd5
    } state_t;

    state_t     r_state;
    logic [4:0] r_pkt_meta;
    logic [4:0] r_pkt_s;
    logic       r_valid_meta;
    logic       r_valid_s;
    logic [4:0] r_lat;
    logic [7:0] r_cnt;
    logic [1:0] r_grid [4][5];
    logic [1:0] r_cur_row;
    logic [2:0] r_cur_col;
    logic       r_cur_valid;
    logic       r_update;
    logic       r_error;
    logic [4:0] r_count;
    logic [1:0] r_rd_data;

    logic [1:0] w_lat_row;
    logic [2:0] w_lat_col;

    assign w_lat_row = r_lat[1:0];
    assign w_lat_col = r_lat[4:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_meta   <= '0;
            r_pkt_s      <= '0;
            r_valid_meta <= 1'b0;
            r_valid_s    <= 1'b0;
        end else begin
            r_pkt_meta   <= bus.packet;
            r_pkt_s      <= r_pkt_meta;
            r_valid_meta <= bus.packet_valid;
            r_valid_s    <= r_valid_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lat       <= '0;
            r_cnt       <= '0;
            r_cur_row   <= '0;
            r_cur_col   <= '0;
            r_cur_valid <= 1'b0;
            r_update    <= 1'b0;
            r_error     <= 1'b0;
            r_count     <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 5; c++) begin
                    r_grid[r][c] <= c_cell_unvisited;
                end
            end
        end else begin
            r_update <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_valid_s) begin
                        r_lat   <= r_pkt_s;
                        r_cnt   <= 8'd1;
                        r_state <= S_FILTER;
                    end
                end
                S_FILTER: begin
                    if (!r_valid_s) begin
                        r_state <= S_IDLE;
                    end else if (r_pkt_s != r_lat) begin
                        r_lat <= r_pkt_s;
                        r_cnt <= 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_stable_last) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_lat_col > c_max_col) begin
                        r_error <= 1'b1;
                        r_state <= S_WAIT_LOW;
                    end else if (r_cur_valid && (w_lat_row == r_cur_row) &&
                                 (w_lat_col == r_cur_col)) begin
                        r_state <= S_WAIT_LOW;
                    end else if (!r_cur_valid) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_grid[r_cur_row][r_cur_col] <= c_cell_visited;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_grid[w_lat_row][w_lat_col] <= c_cell_current;
                    r_cur_row   <= w_lat_row;
                    r_cur_col   <= w_lat_col;
                    r_cur_valid <= 1'b1;
                    r_update    <= 1'b1;
                    // Only a never-visited cell adds to the visited total.
                    if ((r_grid[w_lat_row][w_lat_col] == c_cell_unvisited) &&
                        (r_count != c_all_cells)) begin
                        r_count <= r_count + 5'd1;
                    end
                    r_state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!r_valid_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Same-cycle writes are not forwarded: the old cell value is returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= c_cell_unvisited;
        end else if (bus.rd_col <= c_max_col) begin
            r_rd_data <= r_grid[bus.rd_row][bus.rd_col];
        end else begin
            r_rd_data <= c_cell_unvisited;
        end
    end

    assign bus.rd_data       = r_rd_data;
    assign bus.cur_row       = r_cur_row;
    assign bus.cur_col       = r_cur_col;
    assign bus.cur_valid     = r_cur_valid;
    assign bus.update_pulse  = r_update;
    assign bus.error_pulse   = r_error;
    assign bus.visited_count = r_count;
    assign bus.done          = (r_count == c_all_cells);

endmodule

`default_nettype wire

// File: tb/tb_maze_grid_controller.sv
// ============================================================================
// Module   : tb_maze_grid_controller
// Summary  : Directed and randomized checks of maze_grid_controller against a
//            cell-level reference model of the maze.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_maze_grid_controller;

    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst;

    always #20 clk = ~clk;

    maze_grid_controller_if bus();

    maze_grid_controller #(.STABLE_CYCLES(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cell states 0 unvisited, 1 visited, 2 current.
    int m_grid [4][5];
    int m_row, m_col, m_count;
    bit m_valid;

    int n_upd, n_err, first_upd, first_err, n_overlap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                m_grid[r][c] = 0;
        m_row = 0; m_col = 0; m_count = 0; m_valid = 1'b0;
    endtask

    // Expected pulse positions in edges after E (E = index 0); -1 means none.
    task automatic predict(input logic [4:0] p, output int upd_at, output int err_at);
        int row, col;
        row = int'(p[1:0]);
        col = int'(p[4:2]);
        upd_at = -1;
        err_at = -1;
        if (col > 4) begin
            err_at = STABLE + 2;
        end else if (!(m_valid && row == m_row && col == m_col)) begin
            upd_at = m_valid ? STABLE + 4 : STABLE + 3;
            if (m_valid) m_grid[m_row][m_col] = 1;
            if (m_grid[row][col] == 0) m_count++;
            m_grid[row][col] = 2;
            m_row = row; m_col = col; m_valid = 1'b1;
        end
    endtask

    task automatic clear_obs();
        n_upd = 0; n_err = 0; first_upd = -1; first_err = -1; n_overlap = 0;
    endtask

    task automatic run_cycles(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.update_pulse === 1'b1) begin
                n_upd++;
                if (first_upd < 0) first_upd = base + i;
            end
            if (bus.error_pulse === 1'b1) begin
                n_err++;
                if (first_err < 0) first_err = base + i;
            end
            if (bus.update_pulse === 1'b1 && bus.error_pulse === 1'b1) n_overlap++;
        end
    endtask

    task automatic check_pulses(input string tag, input int exp_upd, input int exp_err);
        check({tag, ".upd_count"}, n_upd, (exp_upd >= 0) ? 1 : 0);
        check({tag, ".upd_edge"}, first_upd, exp_upd);
        check({tag, ".err_count"}, n_err, (exp_err >= 0) ? 1 : 0);
        check({tag, ".err_edge"}, first_err, exp_err);
        check({tag, ".overlap"}, n_overlap, 0);
    endtask

    task automatic send(input string tag, input logic [4:0] p, input int hold, input int low);
        int exp_upd, exp_err;
        predict(p, exp_upd, exp_err);
        clear_obs();
        @(negedge clk);
        bus.packet = p;
        bus.packet_valid = 1'b1;
        run_cycles(hold, 0);
        @(negedge clk);
        bus.packet_valid = 1'b0;
        run_cycles(low, hold);
        check_pulses(tag, exp_upd, exp_err);
    endtask

    task automatic check_state(input string tag);
        int n_cur;
        check({tag, ".cur_valid"}, bus.cur_valid, m_valid);
        check({tag, ".cur_row"}, bus.cur_row, m_row);
        check({tag, ".cur_col"}, bus.cur_col, m_col);
        check({tag, ".count"}, bus.visited_count, m_count);
        check({tag, ".done"}, bus.done, (m_count == 20) ? 1 : 0);
        n_cur = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                bus.rd_row = 2'(r);
                bus.rd_col = 3'(c);
                @(posedge clk);
                #1;
                check($sformatf("%s.cell_%0d_%0d", tag, r, c), bus.rd_data, m_grid[r][c]);
                if (bus.rd_data === 2'b10) n_cur++;
            end
        end
        check({tag, ".one_current"}, n_cur, m_valid ? 1 : 0);
        @(negedge clk);
        bus.rd_row = 2'($urandom_range(0, 3));
        bus.rd_col = 3'($urandom_range(5, 7));
        @(posedge clk);
        #1;
        check({tag, ".rd_out_of_range"}, bus.rd_data, 0);
    endtask

    initial begin
        logic [4:0] tog_vals [4];
        logic [4:0] final_pkt;
        int         exp_upd, exp_err;

        rst = 1'b1;
        bus.packet = '0;
        bus.packet_valid = 1'b0;
        bus.rd_row = '0;
        bus.rd_col = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.update_pulse", bus.update_pulse, 0);
        check("reset.error_pulse", bus.error_pulse, 0);
        check("reset.rd_data", bus.rd_data, 0);
        check_state("reset");

        // First commit, move, out-of-range column, repeat of current cell.
        send("first", 5'b00101, 10, 6);
        check_state("first");
        send("move", 5'b10011, 10, 6);
        check_state("move");
        send("badcol", 5'b10100, 10, 6);
        check_state("badcol");
        send("same", 5'b10011, 10, 6);
        check_state("same");

        // Packet bouncing every 3 cycles, then held with valid high 50+ cycles.
        tog_vals[0] = 5'b00000;
        tog_vals[1] = 5'b01010;
        tog_vals[2] = 5'b00000;
        tog_vals[3] = 5'b01010;
        final_pkt   = 5'b01101;
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.packet = tog_vals[i];
            bus.packet_valid = 1'b1;
            run_cycles(3, -100);
        end
        predict(final_pkt, exp_upd, exp_err);
        @(negedge clk);
        bus.packet = final_pkt;
        run_cycles(60, 0);
        @(negedge clk);
        bus.packet_valid = 1'b0;
        run_cycles(6, 60);
        check_pulses("bounce", exp_upd, exp_err);
        check_state("bounce");

        for (int k = 0; k < 12; k++) begin
            send($sformatf("rand%0d", k), 5'($urandom_range(0, 31)),
                 $urandom_range(STABLE + 3, STABLE + 12), $urandom_range(4, 8));
            check_state($sformatf("rand%0d", k));
        end

        // Reset lands while the new cell write is pending after CLEAR.
        send("pre_rst", 5'b00010, 10, 6);
        clear_obs();
        @(negedge clk);
        bus.packet = 5'b00111;
        bus.packet_valid = 1'b1;
        run_cycles(STABLE + 4, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.packet_valid = 1'b0;
        run_cycles(2, STABLE + 4);
        @(negedge clk);
        rst = 1'b0;
        run_cycles(3, STABLE + 6);
        check("midrst.no_update", n_upd, 0);
        model_reset();
        check_state("midrst");
        send("after_rst", 5'b00111, 10, 6);
        check_state("after_rst");

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                send($sformatf("walk_%0d_%0d", r, c), {3'(c), 2'(r)}, 10, 5);
            end
        end
        check_state("walk");
        send("revisit", 5'b00000, 10, 6);
        check_state("revisit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
